// File: rtl/rv64_ctrl_pkg.sv
// Shared encodings for the RV64I multicycle control sequencer:
// opcodes, FSM state codes and datapath select values.
package rv64_ctrl_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef logic [2:0] state_t;
  localparam state_t ST_FETCH  = 3'd0;
  localparam state_t ST_DECODE = 3'd1;
  localparam state_t ST_EXEC   = 3'd2;
  localparam state_t ST_MEM    = 3'd3;
  localparam state_t ST_WB     = 3'd4;
  localparam state_t ST_FAULT  = 3'd7;

  typedef enum logic [1:0] {PC_PLUS4 = 2'b00, PC_BRANCH = 2'b01, PC_JAL = 2'b10} pc_src_t;
  typedef enum logic [1:0] {WB_ALU = 2'b00, WB_MEM = 2'b01, WB_PC4 = 2'b10} wb_sel_t;
  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10} alu_op_t;
  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_ILLEGAL  = 2'b01,
    FC_FETCH_TO = 2'b10,
    FC_DATA_TO  = 2'b11
  } fault_code_t;

  function automatic logic opcode_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LD) ||
           (op == OP_SD) || (op == OP_BEQ) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/rv64_wait_timer.sv
// Counts consecutive cycles a memory request waits without ready.
// at_limit flags the cycle in which one more unanswered cycle means timeout.
module rv64_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic at_limit
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] cnt_reg;

  assign at_limit = (cnt_reg == W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_reg <= '0;
    end else if (en && !at_limit) begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

endmodule

// File: rtl/rv64_multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV64I datapath.
// Strobes are decoded from the registered state, the latched opcode and the ready inputs.
module rv64_multicycle_ctrl
  import rv64_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             stall,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             mem_read,
  output logic             mem_write,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instret
);

  state_t           state_reg, state_next;
  logic [6:0]       op_reg;
  logic [1:0]       fault_code_reg, fault_code_next;
  logic [CNT_W-1:0] instret_reg;
  logic             retire;
  logic             wait_clr, wait_en, wait_at_limit;
  logic             is_ld;

  rv64_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (wait_clr),
    .en       (wait_en),
    .at_limit (wait_at_limit)
  );

  assign is_ld      = (op_reg == OP_LD);
  assign state_o    = state_reg;
  assign fault      = (state_reg == ST_FAULT);
  assign fault_code = fault_code_reg;
  assign instret    = instret_reg;

  always_comb begin
    imem_req        = 1'b0;
    ir_write        = 1'b0;
    pc_write        = 1'b0;
    pc_src          = PC_PLUS4;
    reg_write       = 1'b0;
    wb_sel          = WB_ALU;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    alu_src         = 1'b0;
    alu_op          = ALU_ADD;
    retire          = 1'b0;
    wait_clr        = 1'b1;
    wait_en         = 1'b0;
    state_next      = state_reg;
    fault_code_next = fault_code_reg;

    case (state_reg)
      ST_FETCH: begin
        // A stalled fetch issues no request, so the timeout restarts afterwards.
        if (!stall) begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_write   = 1'b1;
            state_next = ST_DECODE;
          end else begin
            wait_clr = 1'b0;
            wait_en  = 1'b1;
            if (wait_at_limit) begin
              state_next      = ST_FAULT;
              fault_code_next = FC_FETCH_TO;
            end
          end
        end
      end
      ST_DECODE: begin
        if (opcode_legal(opcode)) begin
          state_next = ST_EXEC;
        end else begin
          state_next      = ST_FAULT;
          fault_code_next = FC_ILLEGAL;
        end
      end
      ST_EXEC: begin
        case (op_reg)
          OP_R: begin
            alu_op     = ALU_FUNCT;
            state_next = ST_WB;
          end
          OP_I: begin
            alu_src    = 1'b1;
            alu_op     = ALU_FUNCT;
            state_next = ST_WB;
          end
          OP_LD, OP_SD: begin
            alu_src    = 1'b1;
            state_next = ST_MEM;
          end
          OP_BEQ: begin
            alu_op     = ALU_SUB;
            pc_write   = 1'b1;
            pc_src     = zero ? PC_BRANCH : PC_PLUS4;
            retire     = 1'b1;
            state_next = ST_FETCH;
          end
          OP_JAL: begin
            pc_write   = 1'b1;
            pc_src     = PC_JAL;
            reg_write  = 1'b1;
            wb_sel     = WB_PC4;
            retire     = 1'b1;
            state_next = ST_FETCH;
          end
          default: begin
            state_next      = ST_FAULT;
            fault_code_next = FC_ILLEGAL;
          end
        endcase
      end
      ST_MEM: begin
        // Address operands stay selected for the whole access.
        alu_src   = 1'b1;
        mem_read  = is_ld;
        mem_write = !is_ld;
        if (dmem_ready) begin
          if (is_ld) begin
            state_next = ST_WB;
          end else begin
            pc_write   = 1'b1;
            retire     = 1'b1;
            state_next = ST_FETCH;
          end
        end else begin
          wait_clr = 1'b0;
          wait_en  = 1'b1;
          if (wait_at_limit) begin
            state_next      = ST_FAULT;
            fault_code_next = FC_DATA_TO;
          end
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        wb_sel     = is_ld ? WB_MEM : WB_ALU;
        pc_write   = 1'b1;
        retire     = 1'b1;
        state_next = ST_FETCH;
      end
      ST_FAULT: begin
        state_next = ST_FAULT;
      end
      default: begin
        state_next = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_FETCH;
      op_reg         <= '0;
      fault_code_reg <= FC_NONE;
      instret_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      fault_code_reg <= fault_code_next;
      if (state_reg == ST_DECODE) begin
        op_reg <= opcode;
      end
      if (retire) begin
        instret_reg <= instret_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rv64_multicycle_ctrl.sv
// Directed bench for rv64_multicycle_ctrl: the driver queues the expected outputs
// of each cycle, a monitor pops and compares them on the falling edge.
module tb_rv64_multicycle_ctrl;
  import rv64_ctrl_pkg::*;

  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

  localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, X = 3'd7;

  // Strobes {imem_req, ir_write, pc_write, reg_write, mem_read, mem_write, alu_src}
  localparam logic [6:0] S_NONE   = 7'b0000000;
  localparam logic [6:0] S_FETCH  = 7'b1100000;
  localparam logic [6:0] S_FWAIT  = 7'b1000000;
  localparam logic [6:0] S_WB     = 7'b0011000;
  localparam logic [6:0] S_IMM    = 7'b0000001;
  localparam logic [6:0] S_LD     = 7'b0000101;
  localparam logic [6:0] S_SD     = 7'b0000011;
  localparam logic [6:0] S_SDDONE = 7'b0010011;
  localparam logic [6:0] S_BR     = 7'b0010000;
  localparam logic [6:0] S_JAL    = 7'b0011000;

  // Selects {pc_src, wb_sel, alu_op}
  localparam logic [5:0] Z6       = 6'b000000;
  localparam logic [5:0] SEL_FN   = 6'b000010;
  localparam logic [5:0] SEL_LDWB = 6'b000100;
  localparam logic [5:0] SEL_BEQT = 6'b010001;
  localparam logic [5:0] SEL_BEQN = 6'b000001;
  localparam logic [5:0] SEL_JAL  = 6'b101000;

  localparam logic [1:0] FC0 = 2'b00;
  localparam logic [6:0] OP_BAD = 7'b0000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opcode = 7'd0;
  logic        zero = 1'b0;
  logic        stall = 1'b0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        imem_req, ir_write, pc_write, reg_write, mem_read, mem_write, alu_src, fault;
  logic [1:0]  pc_src, wb_sel, alu_op, fault_code;
  logic [2:0]  state_o;
  logic [63:0] instret;

  typedef struct packed {
    logic [2:0]  st;
    logic [6:0]  s;
    logic [5:0]  sel;
    logic        flt;
    logic [1:0]  fc;
    logic [63:0] n;
  } sig_t;

  typedef struct {
    string name;
    sig_t  sig;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] n;

  rv64_multicycle_ctrl #(.TIMEOUT(8), .CNT_W(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .stall      (stall),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_req   (imem_req),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .wb_sel     (wb_sel),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .fault      (fault),
    .fault_code (fault_code),
    .state_o    (state_o),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  function automatic sig_t mk(input logic [2:0] st, input logic [6:0] s, input logic [5:0] sel,
                              input logic [1:0] fc, input logic [63:0] cnt);
    sig_t r;
    r.st  = st;
    r.s   = s;
    r.sel = sel;
    r.flt = (st == X);
    r.fc  = fc;
    r.n   = cnt;
    return r;
  endfunction

  task automatic cyc(input string nm, input logic rst, input logic [6:0] op, input logic z,
                     input logic stl, input logic ir, input logic dr, input sig_t e);
    exp_t x;
    reset      = rst;
    opcode     = op;
    zero       = z;
    stall      = stl;
    imem_ready = ir;
    dmem_ready = dr;
    x.name = nm;
    x.sig  = e;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Monitor: one comparison per queued cycle.
  initial begin
    exp_t e;
    sig_t act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {state_o, {imem_req, ir_write, pc_write, reg_write, mem_read, mem_write, alu_src},
               {pc_src, wb_sel, alu_op}, fault, fault_code, instret};
        n_checks++;
        if (act !== e.sig) begin
          n_fail++;
          $display("FAIL %s: got st=%0d strb=%b sel=%b flt=%b fc=%b n=%0d, want st=%0d strb=%b sel=%b flt=%b fc=%b n=%0d",
                   e.name, act.st, act.s, act.sel, act.flt, act.fc, act.n,
                   e.sig.st, e.sig.s, e.sig.sel, e.sig.flt, e.sig.fc, e.sig.n);
        end else begin
          $display("ok   %s: st=%0d strb=%b sel=%b fc=%b n=%0d",
                   e.name, act.st, act.s, act.sel, act.fc, act.n);
        end
      end
    end
  end

  initial begin
    n = 64'd0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc("reset", H, OP_BAD, L, L, L, L, mk(F, S_FWAIT, Z6, FC0, n));

    // R-type
    cyc("r_fetch", L, OP_R, L, L, H, L, mk(F, S_FETCH, Z6, FC0, n));
    cyc("r_dec",   L, OP_R, L, L, H, L, mk(D, S_NONE, Z6, FC0, n));
    cyc("r_exec",  L, OP_R, L, L, H, L, mk(E, S_NONE, SEL_FN, FC0, n));
    cyc("r_wb",    L, OP_R, L, L, H, L, mk(W, S_WB, Z6, FC0, n));
    n = n + 64'd1;

    // I-ALU; the opcode port changes after DECODE and must be ignored
    cyc("i_fetch", L, OP_I,  L, L, H, L, mk(F, S_FETCH, Z6, FC0, n));
    cyc("i_dec",   L, OP_I,  L, L, H, L, mk(D, S_NONE, Z6, FC0, n));
    cyc("i_exec",  L, OP_LD, L, L, H, L, mk(E, S_IMM, SEL_FN, FC0, n));
    cyc("i_wb",    L, OP_LD, L, L, H, L, mk(W, S_WB, Z6, FC0, n));
    n = n + 64'd1;

    // LD, dmem_ready on the third MEM cycle
    cyc("ld_fetch", L, OP_LD, L, L, H, L, mk(F, S_FETCH, Z6, FC0, n));
    cyc("ld_dec",   L, OP_LD, L, L, H, L, mk(D, S_NONE, Z6, FC0, n));
    cyc("ld_exec",  L, OP_LD, L, L, H, L, mk(E, S_IMM, Z6, FC0, n));
    cyc("ld_mem1",  L, OP_LD, L, L, H, L, mk(M, S_LD, Z6, FC0, n));
    cyc("ld_mem2",  L, OP_LD, L, L, H, L, mk(M, S_LD, Z6, FC0, n));
    cyc("ld_mem3",  L, OP_LD, L, L, H, H, mk(M, S_LD, Z6, FC0, n));
    cyc("ld_wb",    L, OP_LD, L, L, H, L, mk(W, S_WB, SEL_LDWB, FC0, n));
    n = n + 64'd1;

    // BEQ taken, with a spurious dmem_ready in DECODE
    cyc("beqt_fetch", L, OP_BEQ, H, L, H, L, mk(F, S_FETCH, Z6, FC0, n));
    cyc("beqt_dec",   L, OP_BEQ, H, L, H, H, mk(D, S_NONE, Z6, FC0, n));
    cyc("beqt_exec",  L, OP_BEQ, H, L, H, L, mk(E, S_BR, SEL_BEQT, FC0, n));
    n = n + 64'd1;

    // BEQ not taken
    cyc("beqn_fetch", L, OP_BEQ, L, L, H, L, mk(F, S_FETCH, Z6, FC0, n));
    cyc("beqn_dec",   L, OP_BEQ, L, L, H, L, mk(D, S_NONE, Z6, FC0, n));
    cyc("beqn_exec",  L, OP_BEQ, L, L, H, L, mk(E, S_BR, SEL_BEQN, FC0, n));
    n = n + 64'd1;

    // JAL
    cyc("jal_fetch", L, OP_JAL, L, L, H, L, mk(F, S_FETCH, Z6, FC0, n));
    cyc("jal_dec",   L, OP_JAL, L, L, H, L, mk(D, S_NONE, Z6, FC0, n));
    cyc("jal_exec",  L, OP_JAL, L, L, H, L, mk(E, S_JAL, SEL_JAL, FC0, n));
    n = n + 64'd1;

    // SD, ready in the first MEM cycle
    cyc("sd_fetch", L, OP_SD, L, L, H, L, mk(F, S_FETCH, Z6, FC0, n));
    cyc("sd_dec",   L, OP_SD, L, L, H, L, mk(D, S_NONE, Z6, FC0, n));
    cyc("sd_exec",  L, OP_SD, L, L, H, L, mk(E, S_IMM, Z6, FC0, n));
    cyc("sd_mem",   L, OP_SD, L, L, H, H, mk(M, S_SDDONE, Z6, FC0, n));
    n = n + 64'd1;

    // SD, ready arrives exactly in the TIMEOUT-th MEM cycle: no fault
    cyc("sd8_fetch", L, OP_SD, L, L, H, L, mk(F, S_FETCH, Z6, FC0, n));
    cyc("sd8_dec",   L, OP_SD, L, L, H, L, mk(D, S_NONE, Z6, FC0, n));
    cyc("sd8_exec",  L, OP_SD, L, L, H, L, mk(E, S_IMM, Z6, FC0, n));
    for (int i = 0; i < 7; i++)
      cyc("sd8_wait", L, OP_SD, L, L, H, L, mk(M, S_SD, Z6, FC0, n));
    cyc("sd8_done",  L, OP_SD, L, L, H, H, mk(M, S_SDDONE, Z6, FC0, n));
    n = n + 64'd1;

    // Fetch waits 5, a stall restarts the wait count, then 7 more waits and ready
    for (int i = 0; i < 5; i++)
      cyc("fw_wait1", L, OP_R, L, L, L, L, mk(F, S_FWAIT, Z6, FC0, n));
    cyc("fw_stall",   L, OP_R, L, H, L, L, mk(F, S_NONE, Z6, FC0, n));
    for (int i = 0; i < 7; i++)
      cyc("fw_wait2", L, OP_R, L, L, L, L, mk(F, S_FWAIT, Z6, FC0, n));
    cyc("fw_fetch", L, OP_R, L, L, H, L, mk(F, S_FETCH, Z6, FC0, n));
    cyc("fw_dec",   L, OP_R, L, L, H, L, mk(D, S_NONE, Z6, FC0, n));
    cyc("fw_exec",  L, OP_R, L, L, H, L, mk(E, S_NONE, SEL_FN, FC0, n));
    cyc("fw_wb",    L, OP_R, L, L, H, L, mk(W, S_WB, Z6, FC0, n));
    n = n + 64'd1;

    // Reset in the middle of an LD access
    cyc("rst_fetch", L, OP_LD, L, L, H, L, mk(F, S_FETCH, Z6, FC0, n));
    cyc("rst_dec",   L, OP_LD, L, L, H, L, mk(D, S_NONE, Z6, FC0, n));
    cyc("rst_exec",  L, OP_LD, L, L, H, L, mk(E, S_IMM, Z6, FC0, n));
    cyc("rst_mem1",  L, OP_LD, L, L, H, L, mk(M, S_LD, Z6, FC0, n));
    cyc("rst_mem2",  H, OP_LD, L, L, H, L, mk(M, S_LD, Z6, FC0, n));
    n = 64'd0;

    // Long stall in FETCH: no request, no fault
    for (int i = 0; i < 100; i++)
      cyc("stall_hold", L, OP_SD, L, H, H, L, mk(F, S_NONE, Z6, FC0, n));

    // SD timeout -> data-timeout fault, ready inputs then ignored
    cyc("sdto_fetch", L, OP_SD, L, L, H, L, mk(F, S_FETCH, Z6, FC0, n));
    cyc("sdto_dec",   L, OP_SD, L, L, H, L, mk(D, S_NONE, Z6, FC0, n));
    cyc("sdto_exec",  L, OP_SD, L, L, H, L, mk(E, S_IMM, Z6, FC0, n));
    for (int i = 0; i < 8; i++)
      cyc("sdto_wait", L, OP_SD, L, L, H, L, mk(M, S_SD, Z6, FC0, n));
    for (int i = 0; i < 3; i++)
      cyc("sdto_fault", L, OP_SD, L, L, H, H, mk(X, S_NONE, Z6, 2'b11, n));
    cyc("sdto_rst",   H, OP_SD, L, L, H, H, mk(X, S_NONE, Z6, 2'b11, n));

    // JAL then an illegal opcode: fault with a frozen nonzero instret
    cyc("jal2_fetch", L, OP_JAL, L, L, H, L, mk(F, S_FETCH, Z6, FC0, n));
    cyc("jal2_dec",   L, OP_JAL, L, L, H, L, mk(D, S_NONE, Z6, FC0, n));
    cyc("jal2_exec",  L, OP_JAL, L, L, H, L, mk(E, S_JAL, SEL_JAL, FC0, n));
    n = n + 64'd1;
    cyc("ill_fetch",  L, OP_BAD, L, L, H, L, mk(F, S_FETCH, Z6, FC0, n));
    cyc("ill_dec",    L, OP_BAD, L, L, H, H, mk(D, S_NONE, Z6, FC0, n));
    for (int i = 0; i < 20; i++)
      cyc("ill_fault", L, OP_R, H, L, H, H, mk(X, S_NONE, Z6, 2'b01, n));
    cyc("ill_rst",    H, OP_R, L, L, L, L, mk(X, S_NONE, Z6, 2'b01, n));
    n = 64'd0;

    // Fetch timeout straight out of reset
    for (int i = 0; i < 8; i++)
      cyc("fto_wait", L, OP_R, L, L, L, L, mk(F, S_FWAIT, Z6, FC0, n));
    for (int i = 0; i < 2; i++)
      cyc("fto_fault", L, OP_R, L, L, H, L, mk(X, S_NONE, Z6, 2'b10, n));
    cyc("fto_rst",  H, OP_R, L, L, L, L, mk(X, S_NONE, Z6, 2'b10, n));
    cyc("post_rst", L, OP_R, L, L, L, L, mk(F, S_FWAIT, Z6, FC0, n));

    repeat (3) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
